// File: rtl/led_digit_seq_if.sv
// Bus between a controller and the three-digit LED frame sequencer.
// Handshake: a request is taken when i_start is high on a clock edge while the sequencer is idle;
// o_busy stays high until the sequence ends, and o_done marks that end for one cycle.
interface led_digit_seq_if;
    logic       i_start;
    logic [4:0] i_100;
    logic [4:0] i_010;
    logic [4:0] i_001;
    logic [7:0] o_led;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [2:0] o_state;

    modport slave (
        input  i_start, i_100, i_010, i_001,
        output o_led, o_busy, o_done, o_err, o_state
    );

    modport master (
        output i_start, i_100, i_010, i_001,
        input  o_led, o_busy, o_done, o_err, o_state
    );
endinterface

// File: rtl/led_digit_seq.sv
// Samples three Gray-coded digits until they are stable, then shows them as
// hundreds/tens/ones frames on o_led, with optional blank gaps between the frames.
module led_digit_seq #(
    parameter int pHOLD  = 1000,
    parameter int pGAP   = 100,
    parameter int pRETRY = 8
) (
    input logic            i_clk,
    input logic            i_rst,
    led_digit_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, SHOW_H, GAP_H, SHOW_T, GAP_T, SHOW_O, GAP_O
    } state_t;

    localparam logic [15:0] HOLD_LD    = 16'(pHOLD - 1);
    localparam logic [15:0] GAP_LD     = 16'(pGAP - 1);
    localparam logic [7:0]  RETRY_LAST = 8'(pRETRY - 1);
    localparam bit          GAP_NONE   = (pGAP == 0);

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic digit_bad(input logic [4:0] g);
        return gray2bin(g) > 5'd9;
    endfunction

    function automatic logic [7:0] frame(input logic [1:0] pos, input logic [4:0] g);
        logic [4:0] b;
        b = gray2bin(g);
        if (b > 5'd9) return {pos, 1'b1, 1'b0, 4'hF};
        return {pos, 2'b00, b[3:0]};
    endfunction

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  scnt;
    logic [14:0] prev;
    logic [9:0]  lat;
    logic [7:0]  led;
    logic        busy, done, err;

    logic [14:0] cur;
    logic        match, is_show, is_gap, adv, last;
    state_t      nxt_show, gap_of;
    logic [1:0]  nxt_pos;
    logic [4:0]  nxt_digit;

    assign cur   = {bus.i_100, bus.i_010, bus.i_001};
    assign match = (scnt != 8'd0) && (cur == prev);

    // What follows the current show/gap state; hundreds are never "next" since they come from SAMPLE.
    always_comb begin
        nxt_show  = SHOW_O;
        gap_of    = GAP_O;
        nxt_pos   = 2'b01;
        nxt_digit = lat[4:0];
        last      = 1'b1;
        case (state)
            SHOW_H, GAP_H: begin
                nxt_show  = SHOW_T;
                gap_of    = GAP_H;
                nxt_pos   = 2'b10;
                nxt_digit = lat[9:5];
                last      = 1'b0;
            end
            SHOW_T, GAP_T: begin
                nxt_show  = SHOW_O;
                gap_of    = GAP_T;
                nxt_pos   = 2'b01;
                nxt_digit = lat[4:0];
                last      = 1'b0;
            end
            default: ;
        endcase
    end

    assign is_show = (state == SHOW_H) || (state == SHOW_T) || (state == SHOW_O);
    assign is_gap  = (state == GAP_H)  || (state == GAP_T)  || (state == GAP_O);
    assign adv     = (cnt == 16'd0) && ((is_show && GAP_NONE) || is_gap);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            scnt  <= '0;
            prev  <= '0;
            lat   <= '0;
            led   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (adv) begin
                if (last) begin
                    state <= IDLE;
                    led   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= nxt_show;
                    cnt   <= HOLD_LD;
                    led   <= frame(nxt_pos, nxt_digit);
                    err   <= err | digit_bad(nxt_digit);
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_start) begin
                            state <= SAMPLE;
                            scnt  <= '0;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end
                    end
                    SAMPLE: begin
                        // A repeat of the previous sample latches cleanly; running out of retries latches anyway.
                        if (match || (scnt == RETRY_LAST)) begin
                            lat   <= cur[9:0];
                            state <= SHOW_H;
                            cnt   <= HOLD_LD;
                            led   <= frame(2'b11, cur[14:10]);
                            err   <= err | !match | digit_bad(cur[14:10]);
                        end else begin
                            prev <= cur;
                            scnt <= scnt + 8'd1;
                        end
                    end
                    SHOW_H, SHOW_T, SHOW_O: begin
                        if (cnt == 16'd0) begin
                            state <= gap_of;
                            cnt   <= GAP_LD;
                            led   <= '0;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    default: cnt <= cnt - 16'd1;
                endcase
            end
        end
    end

    assign bus.o_led   = led;
    assign bus.o_busy  = busy;
    assign bus.o_done  = done;
    assign bus.o_err   = err;
    assign bus.o_state = state;

endmodule

// File: tb/tb_led_digit_seq.sv
// Bench for led_digit_seq: two configurations (with and without gaps) checked
// cycle by cycle against an expected-trace model built from the digit rules.
module tb_led_digit_seq;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    led_digit_seq_if if_a ();
    led_digit_seq_if if_b ();

    led_digit_seq #(.pHOLD(4), .pGAP(2), .pRETRY(8)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .bus(if_a.slave)
    );
    led_digit_seq #(.pHOLD(3), .pGAP(0), .pRETRY(4)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .bus(if_b.slave)
    );

    typedef struct {
        logic [7:0] led;
        logic       busy;
        logic       done;
        logic       err;
        logic       chk_err;
    } exp_t;

    exp_t exp_q[$];
    int   g2b[32];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic int p_hold(input int sel);
        return (sel == 0) ? 4 : 3;
    endfunction
    function automatic int p_gap(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction
    function automatic int p_retry(input int sel);
        return (sel == 0) ? 8 : 4;
    endfunction

    function automatic logic [4:0] to_gray(input int v);
        return 5'(v ^ (v >> 1));
    endfunction

    function automatic logic [4:0] rand_digit();
        return to_gray($urandom_range(0, 12));
    endfunction

    function automatic logic [14:0] rand_word();
        return {rand_digit(), rand_digit(), rand_digit()};
    endfunction

    function automatic logic [7:0] exp_frame(input logic [1:0] pos, input logic [4:0] g);
        int v;
        v = g2b[g];
        if (v > 9) return {pos, 1'b1, 1'b0, 4'hF};
        return {pos, 2'b00, 4'(v)};
    endfunction

    task automatic drive(input int sel, input logic st, input logic [14:0] d);
        if (sel == 0) begin
            if_a.i_start = st;
            {if_a.i_100, if_a.i_010, if_a.i_001} = d;
        end else begin
            if_b.i_start = st;
            {if_b.i_100, if_b.i_010, if_b.i_001} = d;
        end
    endtask

    task automatic observe(input int sel, output logic [7:0] led, output logic busy,
                           output logic done, output logic err);
        if (sel == 0) begin
            led = if_a.o_led; busy = if_a.o_busy; done = if_a.o_done; err = if_a.o_err;
        end else begin
            led = if_b.o_led; busy = if_b.o_busy; done = if_b.o_done; err = if_b.o_err;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input int sel, input logic exp_err, input string tag);
        logic [7:0] led;
        logic busy, done, err;
        observe(sel, led, busy, done, err);
        check(tag, {5'd0, led, busy, done, err}, {5'd0, 8'h00, 1'b0, 1'b0, exp_err});
    endtask

    // Builds the expected per-cycle trace from the sampling and display rules, then runs one sequence.
    task automatic run_seq(input int sel, input logic [14:0] ins[16], input bit hold,
                           input bit keep, input string tag);
        int         lat_at, n, pulse_at, hd, gp, rt;
        bit         forced, err_exp;
        logic [14:0] latw;
        logic [4:0]  dg[3];
        logic [1:0]  ps[3];
        logic [7:0]  led;
        logic        busy, done, err;
        exp_t        e;
        hd = p_hold(sel); gp = p_gap(sel); rt = p_retry(sel);
        lat_at = rt;
        forced = 1'b1;
        for (int j = 2; j <= rt; j++) begin
            if (ins[j] == ins[j-1]) begin
                lat_at = j;
                forced = 1'b0;
                break;
            end
        end
        latw = ins[lat_at];
        dg[0] = latw[14:10]; dg[1] = latw[9:5]; dg[2] = latw[4:0];
        ps[0] = 2'b11;       ps[1] = 2'b10;     ps[2] = 2'b01;
        err_exp = forced;
        exp_q.delete();
        for (int c = 0; c < lat_at; c++) exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, c == 0});
        for (int d = 0; d < 3; d++) begin
            if (g2b[dg[d]] > 9) err_exp = 1'b1;
            for (int c = 0; c < hd; c++) exp_q.push_back('{exp_frame(ps[d], dg[d]), 1'b1, 1'b0, 1'b0, 1'b0});
            for (int c = 0; c < gp; c++) exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        exp_q.push_back('{8'h00, 1'b0, 1'b1, err_exp, 1'b1});
        n = exp_q.size();
        pulse_at = hold ? -1 : int'($urandom_range(0, n - 2));
        drive(sel, 1'b1, ins[0]);
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            observe(sel, led, busy, done, err);
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, c), {6'd0, led, busy, done}, {6'd0, e.led, e.busy, e.done});
            if (e.chk_err) check($sformatf("%s_err_c%0d", tag, c), {15'd0, err}, {15'd0, e.err});
            drive(sel, (c == n - 1) ? keep : (hold || c == pulse_at),
                  (c + 1 <= lat_at) ? ins[c+1] : rand_word());
        end
    endtask

    logic [14:0] ins[16];
    logic [14:0] wa, wb;
    logic [7:0]  led;
    logic        busy, done, err;

    initial begin
        for (int v = 0; v < 32; v++) g2b[v ^ (v >> 1)] = v;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_idle(0, 1'b0, "reset_a");
        check_idle(1, 1'b0, "reset_b");
        i_rst = 1'b0;

        // Reference sequence 3,7,5 with gaps
        for (int j = 0; j < 16; j++) ins[j] = {5'b00010, 5'b00100, 5'b00111};
        run_seq(0, ins, 1'b0, 1'b0, "ref375");
        @(posedge i_clk); #1;
        check_idle(0, 1'b0, "ref375_after");

        // Invalid hundreds digit: sticky error, then cleared by the next start
        for (int j = 0; j < 16; j++) ins[j] = {5'b01010, 5'b00100, 5'b00111};
        run_seq(0, ins, 1'b0, 1'b0, "bad_h");
        @(posedge i_clk); #1;
        check_idle(0, 1'b1, "bad_h_after");
        for (int j = 0; j < 16; j++) ins[j] = {5'b00010, 5'b00000, 5'b00001};
        run_seq(0, ins, 1'b0, 1'b0, "err_clear");

        // Inputs toggling every cycle: forced latch of the last sample
        wa = rand_word();
        wb = wa ^ 15'h0421;
        for (int j = 0; j < 16; j++) ins[j] = (j % 2 == 0) ? wa : wb;
        run_seq(0, ins, 1'b0, 1'b0, "toggle");

        // Inputs settle exactly on the last retry cycle
        wa = rand_word();
        for (int j = 0; j < 8; j++) ins[j] = wa ^ 15'(j * 9);
        for (int j = 8; j < 16; j++) ins[j] = ins[7];
        run_seq(0, ins, 1'b0, 1'b0, "late_match");

        // No-gap configuration: 9,0,3 back to back
        for (int j = 0; j < 16; j++) ins[j] = {5'b01101, 5'b00000, 5'b00010};
        run_seq(1, ins, 1'b0, 1'b0, "nogap903");

        // Random digits with random settling on both configurations
        for (int r = 0; r < 12; r++) begin
            ins[0] = rand_word();
            for (int j = 1; j < 16; j++)
                ins[j] = ($urandom_range(0, 2) == 0) ? ins[j-1] : rand_word();
            run_seq(r % 2, ins, 1'b0, 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset during the tens frame aborts without a done pulse
        wa = {rand_digit(), rand_digit(), rand_digit()};
        drive(0, 1'b1, wa);
        @(posedge i_clk); #1;
        drive(0, 1'b0, wa);
        repeat (9) @(posedge i_clk);
        #1;
        observe(0, led, busy, done, err);
        check("pre_rst_tens", {8'd0, led}, {8'd0, exp_frame(2'b10, wa[9:5])});
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check_idle(0, 1'b0, "rst_abort");
        @(posedge i_clk); #1;
        check_idle(0, 1'b0, "rst_no_done");
        for (int j = 0; j < 16; j++) ins[j] = rand_word();
        for (int j = 2; j < 16; j++) ins[j] = ins[1];
        run_seq(0, ins, 1'b0, 1'b0, "post_rst");

        // Start held high: sequences chain with no idle cycle between them
        for (int s = 0; s < 3; s++) begin
            ins[0] = rand_word();
            for (int j = 1; j < 16; j++)
                ins[j] = ($urandom_range(0, 1) == 0) ? ins[j-1] : rand_word();
            run_seq(0, ins, 1'b1, s != 2, $sformatf("chain%0d", s));
        end
        @(posedge i_clk); #1;
        observe(0, led, busy, done, err);
        check("chain_end", {6'd0, led, busy, done}, {6'd0, 8'h00, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_digit_seq.md
LED_DIGIT_SEQ -- requirements
Module: led_digit_seq

Interface
REQ-001 SHALL have parameter pHOLD, default 1000, i_clk cycles each digit frame is shown (range 1..65535).
REQ-002 SHALL have parameter pGAP, default 100, i_clk cycles of blank between frames (0 = no gap).
REQ-003 SHALL have parameter pRETRY, default 8, maximum sample cycles before forced latch (range 2..255).
REQ-004 i_clk  input  1  clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  request one display sequence; level sampled per cycle.
REQ-007 i_100  input  5  hundreds digit, reflected Gray code, synchronous to i_clk.
REQ-008 i_010  input  5  tens digit, reflected Gray code.
REQ-009 i_001  input  5  ones digit, reflected Gray code.
REQ-010 o_led  output  8  registered frame: [7:6] position (11 hundreds, 10 tens, 01 ones, 00 blank), [5] digit invalid, [4] 0, [3:0] binary digit.
REQ-011 o_busy  output  1  high from start acceptance until return to IDLE.
REQ-012 o_done  output  1  one-cycle pulse on return to IDLE.
REQ-013 o_err  output  1  sticky: invalid digit or stability timeout in current/last sequence.

Function
REQ-014 States: IDLE, SAMPLE, SHOW_H, GAP_H, SHOW_T, GAP_T, SHOW_O, GAP_O.
REQ-015 IDLE with i_start=1 at edge k: -> SAMPLE, sample counter=0, o_busy=1, o_err cleared.
REQ-016 i_start while not IDLE SHALL be ignored (no queueing).
REQ-017 SAMPLE: each cycle register the 15-bit input concatenation as prev, counter+1.
REQ-018 SAMPLE, counter!=0 and inputs==prev: latch inputs, -> SHOW_H; with stable inputs hundreds frame is on o_led after edge k+2.
REQ-019 SAMPLE, counter==pRETRY-1 without match: latch current inputs, set o_err, -> SHOW_H.
REQ-020 Gray-to-binary per digit: b[4]=g[4]; b[i]=b[i+1]^g[i] for i=3..0.
REQ-021 Binary value >9: o_led[3:0]=4'hF, o_led[5]=1, o_err set; else o_led[5]=0, o_led[3:0]=value.
REQ-022 Each SHOW_x lasts exactly pHOLD cycles with o_led constant at that digit's frame.
REQ-023 Each GAP_x lasts exactly pGAP cycles with o_led=8'h00; pGAP=0 skips GAP_x (SHOW_H -> SHOW_T directly).
REQ-024 Order: SHOW_H, GAP_H, SHOW_T, GAP_T, SHOW_O, GAP_O, IDLE.
REQ-025 Entering IDLE: o_busy=0, o_led=8'h00, o_done=1 for exactly that cycle; o_err retained.
REQ-026 Latched digits SHALL not change during SHOW/GAP regardless of input activity.
REQ-027 Hold/gap counters SHALL be 16 bits, reload on each state entry, never wrap inside a state.
REQ-028 i_start high on the o_done cycle SHALL start a new sequence (IDLE accepts in that cycle).

Reset
REQ-029 i_rst=1 at any edge: state=IDLE, o_led=8'h00, o_busy=0, o_done=0, o_err=0, counters and latches cleared.
REQ-030 Reset mid-sequence SHALL abort without o_done; reset has priority over i_start.

Verification
REQ-031 pHOLD=4, pGAP=2, inputs 00010/00100/00111 stable, start pulse at k -> o_led=8'hC3 cycles k+2..k+5, 00 k+6..k+7, 8'h87 k+8..k+11, 00, 8'h45 k+14..k+17, 00 k+18..k+19, o_done at k+20, o_err=0.
REQ-032 Hundreds=01010 (12) -> hundreds frame 8'hEF, o_err=1 after sequence; next start clears o_err.
REQ-033 Inputs toggling every cycle, pRETRY=8 -> SHOW_H entered at k+8, o_err=1, frames show last sample.
REQ-034 pGAP=0, digits 01101/00000/00010 (9,0,3) -> frames 8'hC9, 8'h80, 8'h43 back-to-back, pHOLD each, no blank.
REQ-035 i_rst pulsed during SHOW_T -> next cycle o_led=00, o_busy=0, no o_done; i_start held during busy ignored, later start runs full sequence.
REQ-036 i_start held continuously -> sequences repeat back-to-back; each o_done followed by SAMPLE next cycle.
